// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: shared types and defaults for the
// truth-table scan controller.
package tt_scan_pkg;

  localparam int N_IN_DEF   = 2;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: counts hold cycles for one stimulus
// vector and flags the final settle cycle.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam int CW = 4;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // load clears, enable advances one per cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/tt_scan_ctrl.sv
// tt_scan_ctrl: walks every input vector through two
// implementations and records where their outputs differ.
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   a_in,
  input  logic                   b_in,
  output logic [N_IN-1:0]        x,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [(1<<N_IN)-1:0]   mismatch_map,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_vld
);

  localparam int V = 1 << N_IN;

  state_e state_q;
  state_e state_d;

  logic [N_IN-1:0] x_q;
  logic [N_IN-1:0] x_d;
  logic [N_IN:0]   cnt_q;
  logic [N_IN:0]   cnt_d;
  logic [V-1:0]    map_q;
  logic [V-1:0]    map_d;
  logic [N_IN-1:0] ff_q;
  logic [N_IN-1:0] ff_d;
  logic            ffv_q;
  logic            ffv_d;

  logic idle_like;
  logic in_settle;
  logic in_sample;
  logic launch;
  logic last_vec;
  logic mism;
  logic tmr_load;
  logic tmr_tc;

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_DONE);
  assign in_settle = (state_q == S_SETTLE);
  assign in_sample = (state_q == S_SAMPLE);
  assign launch    = idle_like && start;
  assign last_vec  = (x_q == {N_IN{1'b1}});
  assign mism      = a_in ^ b_in;
  assign tmr_load  = launch ||
                     (in_sample && !abort && !last_vec);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .enable (in_settle),
    .tc     (tmr_tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; abort beats sample completion
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)       state_d = S_IDLE;
        else if (tmr_tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)         state_d = S_IDLE;
        else if (last_vec) state_d = S_DONE;
        else               state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // status outputs decoded from registered state
  always_comb begin
    busy = in_settle || in_sample;
    done = (state_q == S_DONE);
    pass = done && (cnt_q == '0);
  end

  // vector and result bookkeeping
  always_comb begin
    x_d   = x_q;
    cnt_d = cnt_q;
    map_d = map_q;
    ff_d  = ff_q;
    ffv_d = ffv_q;
    if (launch) begin
      x_d   = '0;
      cnt_d = '0;
      map_d = '0;
      ff_d  = '0;
      ffv_d = 1'b0;
    end else if (in_sample) begin
      if (mism) begin
        map_d[x_q] = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (!ffv_q) begin
          ff_d  = x_q;
          ffv_d = 1'b1;
        end
      end
      if (!abort && !last_vec) begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      cnt_q <= '0;
      map_q <= '0;
      ff_q  <= '0;
      ffv_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      cnt_q <= cnt_d;
      map_q <= map_d;
      ff_q  <= ff_d;
      ffv_q <= ffv_d;
    end
  end

  assign x              = x_q;
  assign mismatch_cnt   = cnt_q;
  assign mismatch_map   = map_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// tb_tt_scan_ctrl: two scan controllers (SETTLE 1 and 3)
// checked every cycle against a timing-formula model.
module tb_tt_scan_ctrl;

  localparam int V = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [V-1:0] tt_a = '0;
  logic [V-1:0] tt_b = '0;

  logic [1:0] x_o   [2];
  logic [2:0] cnt_o [2];
  logic [3:0] map_o [2];
  logic [1:0] ff_o  [2];
  logic [1:0] busy_o;
  logic [1:0] done_o;
  logic [1:0] pass_o;
  logic [1:0] ffv_o;
  logic [1:0] a_o;
  logic [1:0] b_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign a_o[g] = tt_a[x_o[g]];
    assign b_o[g] = tt_b[x_o[g]];
    tt_scan_ctrl #(
      .N_IN   (2),
      .SETTLE ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .a_in           (a_o[g]),
      .b_in           (b_o[g]),
      .x              (x_o[g]),
      .busy           (busy_o[g]),
      .done           (done_o[g]),
      .pass           (pass_o[g]),
      .mismatch_cnt   (cnt_o[g]),
      .mismatch_map   (map_o[g]),
      .first_fail     (ff_o[g]),
      .first_fail_vld (ffv_o[g])
    );
  end

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h t=%0t",
               nm, d, act, exp, $time);
    end
  endtask

  // model: k = edges since the accepted start edge
  int m_scan [2];
  int m_done [2];
  int m_k    [2];
  int m_n    [2];
  int m_x    [2];
  logic [V-1:0] m_ta [2];
  logic [V-1:0] m_tb [2];

  function automatic int sv(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_scan[d] = 0;
        m_done[d] = 0;
        m_k[d]    = 0;
        m_n[d]    = 0;
        m_x[d]    = 0;
      end else if (m_scan[d] == 0) begin
        if (start) begin
          m_scan[d] = 1;
          m_done[d] = 0;
          m_k[d]    = 0;
          m_ta[d]   = tt_a;
          m_tb[d]   = tt_b;
        end
      end else if (abort) begin
        m_scan[d] = 0;
        m_n[d]    = (m_k[d] + 1) / (sv(d) + 1);
        if (m_n[d] > V) m_n[d] = V;
        m_x[d]    = m_k[d] / (sv(d) + 1);
      end else begin
        m_k[d]++;
        if (m_k[d] == V * (sv(d) + 1)) begin
          m_scan[d] = 0;
          m_done[d] = 1;
        end
      end
    end
  end

  function automatic int exp_n(input int d);
    if (m_scan[d] != 0) return m_k[d] / (sv(d) + 1);
    if (m_done[d] != 0) return V;
    return m_n[d];
  endfunction

  function automatic int exp_x(input int d);
    if (m_scan[d] != 0) return m_k[d] / (sv(d) + 1);
    if (m_done[d] != 0) return V - 1;
    return m_x[d];
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    int n;
    int cnt;
    int ff;
    bit fv;
    logic [3:0] map;
    for (int d = 0; d < 2; d++) begin
      n   = exp_n(d);
      cnt = 0;
      ff  = 0;
      fv  = 1'b0;
      map = '0;
      for (int i = 0; i < n; i++) begin
        if (m_ta[d][i] !== m_tb[d][i]) begin
          cnt++;
          map[i] = 1'b1;
          if (!fv) begin
            fv = 1'b1;
            ff = i;
          end
        end
      end
      chk("x", d, 32'(x_o[d]), 32'(exp_x(d)));
      chk("busy", d, 32'(busy_o[d]), 32'(m_scan[d] != 0));
      chk("done", d, 32'(done_o[d]), 32'(m_done[d] != 0));
      chk("pass", d, 32'(pass_o[d]),
          32'((m_done[d] != 0) && (cnt == 0)));
      chk("cnt", d, 32'(cnt_o[d]), 32'(cnt));
      chk("map", d, 32'(map_o[d]), 32'(map));
      chk("ff", d, 32'(ff_o[d]), 32'(ff));
      chk("ffv", d, 32'(ffv_o[d]), 32'(fv));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input int extra,
                          output int c0, output int c1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    c0 = -1;
    c1 = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k - 1 == extra);
      cyc();
      if (done_o[0] && c0 < 0) c0 = k;
      if (done_o[1] && c1 < 0) c1 = k;
      if (c0 >= 0 && c1 >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic lit_res(input string nm, input int d,
                         input int cnt, input int map,
                         input int ff, input int ffv,
                         input int pass);
    chk({nm, "_cnt"}, d, 32'(cnt_o[d]), 32'(cnt));
    chk({nm, "_map"}, d, 32'(map_o[d]), 32'(map));
    chk({nm, "_ff"}, d, 32'(ff_o[d]), 32'(ff));
    chk({nm, "_ffv"}, d, 32'(ffv_o[d]), 32'(ffv));
    chk({nm, "_pass"}, d, 32'(pass_o[d]), 32'(pass));
  endtask

  initial begin
    int c0;
    int c1;
    repeat (3) cyc();
    chk("rst_x", 0, 32'(x_o[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("rst_done", 0, 32'(done_o[0]), 32'd0);
    rst_n = 1'b1;
    cyc();

    tt_a = 4'b0010;
    tt_b = 4'b0001;
    run_scan(-10, c0, c1);
    chk("scan_cyc", 0, 32'(c0), 32'd8);
    chk("scan_cyc", 1, 32'(c1), 32'd16);
    lit_res("scan", 0, 2, 4'b0011, 0, 1, 0);
    lit_res("scan", 1, 2, 4'b0011, 0, 1, 0);

    tt_a = 4'b0001;
    tt_b = 4'b0001;
    run_scan(-10, c0, c1);
    chk("eq_cyc", 0, 32'(c0), 32'd8);
    lit_res("eq", 0, 0, 0, 0, 0, 1);

    tt_a = 4'b0010;
    tt_b = 4'b0001;
    run_scan(3, c0, c1);
    chk("restart_ign_cyc", 0, 32'(c0), 32'd8);
    chk("restart_ign_cyc", 1, 32'(c1), 32'd16);
    run_scan(-10, c0, c1);
    chk("rescan_cyc", 0, 32'(c0), 32'd8);
    lit_res("rescan", 0, 2, 4'b0011, 0, 1, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("abort_done", 0, 32'(done_o[0]), 32'd0);
    chk("abort_cnt", 0, 32'(cnt_o[0]), 32'd2);
    chk("abort_x", 0, 32'(x_o[0]), 32'd2);
    chk("abort_cnt", 1, 32'(cnt_o[1]), 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("after_abort_x", 0, 32'(x_o[0]), 32'd0);
    chk("after_abort_cnt", 0, 32'(cnt_o[0]), 32'd0);
    repeat (20) cyc();
    lit_res("after_abort", 0, 2, 4'b0011, 0, 1, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("arst_x", 0, 32'(x_o[0]), 32'd0);
    chk("arst_cnt", 0, 32'(cnt_o[0]), 32'd0);
    chk("arst_map", 0, 32'(map_o[0]), 32'd0);
    chk("arst_ffv", 0, 32'(ffv_o[0]), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_scan(-10, c0, c1);
    chk("post_rst_cyc", 0, 32'(c0), 32'd8);
    lit_res("post_rst", 0, 2, 4'b0011, 0, 1, 0);

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 11) == 0);
      abort = ($urandom_range(0, 19) == 0);
      if (start && m_scan[0] == 0 && m_scan[1] == 0) begin
        tt_a = 4'($urandom);
        tt_b = 4'($urandom);
        if ($urandom_range(0, 3) == 0) tt_b = tt_a;
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_scan_ctrl.md
TT_SCAN_CTRL -- requirements
Module: tt_scan_ctrl

Interface
REQ-001 Parameter N_IN, default 2, width of the stimulus vector (number of gate inputs under test), legal range 1..8.
REQ-002 Parameter SETTLE, default 1, cycles each vector is held before sampling, legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a full truth-table scan; sampled in IDLE or DONE only.
REQ-006 abort  input  1  terminate a scan in progress; returns to IDLE.
REQ-007 a_in  input  1  output of implementation A (combinational from x).
REQ-008 b_in  input  1  output of implementation B (combinational from x).
REQ-009 x  output  N_IN  stimulus vector driven to both implementations.
REQ-010 busy  output  1  high in SETTLE and SAMPLE states.
REQ-011 done  output  1  high in DONE state (level, held until next start or reset).
REQ-012 pass  output  1  done and mismatch_cnt == 0.
REQ-013 mismatch_cnt  output  N_IN+1  number of vectors where a_in != b_in.
REQ-014 mismatch_map  output  2**N_IN  bit i set iff vector i mismatched.
REQ-015 first_fail  output  N_IN  lowest-index mismatching vector; valid when first_fail_vld.
REQ-016 first_fail_vld  output  1  at least one mismatch recorded in current scan.

Function
REQ-017 FSM states IDLE, SETTLE, SAMPLE, DONE; registered state, registered outputs.
REQ-018 IDLE/DONE with start=1: x<=0, clear mismatch_cnt, mismatch_map, first_fail, first_fail_vld, settle counter<=0, go SETTLE.
REQ-019 SETTLE: counter increments each cycle; when counter == SETTLE-1 go SAMPLE; x held constant.
REQ-020 SAMPLE: compare a_in vs b_in in this cycle; on mismatch set mismatch_map[x], increment mismatch_cnt, and if !first_fail_vld load first_fail<=x, first_fail_vld<=1.
REQ-021 SAMPLE with x == all-ones: go DONE, x held at all-ones; else x<=x+1, counter<=0, go SETTLE.
REQ-022 Each vector occupies exactly SETTLE+1 cycles; done rises 2**N_IN*(SETTLE+1) cycles after the start edge.
REQ-023 x increments in natural binary order 0..2**N_IN-1; no wrap past all-ones.
REQ-024 start while busy is ignored.
REQ-025 abort while busy: go IDLE next edge, done stays low, result outputs retain partial values; abort wins over simultaneous SAMPLE completion (last compare still recorded).
REQ-026 abort in IDLE or DONE has no effect; start and abort together in IDLE/DONE: abort ignored, scan starts.
REQ-027 mismatch_cnt cannot overflow (max 2**N_IN fits N_IN+1 bits).

Reset
REQ-028 rst_n low asynchronously forces IDLE, x=0, busy=0, done=0, pass=0, mismatch_cnt=0, mismatch_map=0, first_fail=0, first_fail_vld=0, counter=0.
REQ-029 Reset mid-scan discards all partial results; first start after release begins at vector 0.

Structure
REQ-030 Package tt_scan_pkg holds the state enum and default values of N_IN and SETTLE.
REQ-031 One sub-module tt_settle_timer (load, enable, terminal-count flag) implements REQ-019; all else in tt_scan_ctrl.

Verification
REQ-032 N_IN=2, SETTLE=1, a_in=~x[1]&x[0], b_in=~x[1]&~x[0], pulse start -> done high 8 cycles later, mismatch_cnt=2, mismatch_map=4'b0011, first_fail=2'b00, pass=0.
REQ-033 a_in=b_in=~x[1]&~x[0], start -> done after 8 cycles, mismatch_cnt=0, map=0, first_fail_vld=0, pass=1.
REQ-034 SETTLE=3, same stimulus as REQ-032 -> each x value held exactly 4 cycles, done after 16 cycles, same results.
REQ-035 start pulsed again at cycle 3 of a scan -> ignored, done still at cycle 8; start in DONE -> results cleared, rescan completes identically.
REQ-036 abort at cycle 5 (vector 2) -> IDLE next edge, done=0, mismatch_cnt=2 retained; subsequent start -> full scan from x=0.
REQ-037 rst_n low at cycle 4 asynchronously -> all outputs zero within same cycle; after release start -> full correct scan.
